// File: rtl/gates_bist.sv
// gates_bist: built-in self test for a 2-input gate block (OR/AND/XOR/XNOR/NAND/NOR/SUM).
// Sweeps the four input vectors 00,01,10,11, waits SETTLE cycles per vector,
// then compares the 7-bit result against the known truth table.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start          launch a sweep (sampled only while idle)
//   a_out, b_out   registered drive to the gate block inputs (a_out = vector MSB)
//   y_in           gate block results [0]OR [1]AND [2]XOR [3]XNOR [4]NAND [5]NOR [6]SUM
//   busy           high whenever a sweep is in progress
//   done           one-cycle pulse when a sweep completes
//   pass           last completed sweep had no mismatches
//   fail_mask      bit i set when vector i mismatched in the last sweep
//   err_count      number of mismatched vectors in the last sweep
module gates_bist #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    localparam logic [3:0] LOAD = 4'(SETTLE);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [6:0] expv;
    logic       mism;

    always_comb expv = idx == 2'd0 ? 7'h38 : idx == 2'd3 ? 7'h0B : 7'h55;
    // Case inequality so that X/Z on any result bit is reported as a mismatch.
    always_comb mism = (y_in !== expv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            err_count <= 3'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state          <= DRIVE;
                    busy           <= 1'b1;
                    idx            <= 2'd0;
                    {a_out, b_out} <= 2'b00;
                    pass           <= 1'b0;
                    fail_mask      <= 4'd0;
                    err_count      <= 3'd0;
                end
                DRIVE: begin
                    cnt   <= LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= cnt == 4'd1 ? CHECK : WAIT;
                end
                CHECK: begin
                    if (mism) begin
                        fail_mask[idx] <= 1'b1;
                        err_count      <= err_count + 3'(err_count != 3'd4);
                    end
                    if (idx == 2'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                        // Include this final vector's result, not yet visible in err_count.
                        pass  <= (err_count == 3'd0) && !mism;
                    end else begin
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                        state          <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gates_bist.md
GATES_BIST -- requirements
Module: gates_bist

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning the number of wait cycles between driving a vector and sampling y_in; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a test sweep; sampled only in IDLE.
REQ-005 a_out  output  1  registered drive to the gate block's a input.
REQ-006 b_out  output  1  registered drive to the gate block's b input.
REQ-007 y_in  input  7  gate block result vector; bit order [0]OR [1]AND [2]XOR [3]XNOR [4]NAND [5]NOR [6]1-bit SUM.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at end of sweep.
REQ-010 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-011 fail_mask  output  4  bit i set when vector i mismatched in the last sweep.
REQ-012 err_count  output  3  number of mismatched vectors in the last sweep, 0..4.

Function
REQ-013 The block SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE; all outputs SHALL be registered.
REQ-014 IDLE -> DRIVE on a clock edge with start=1; start=1 in any other state SHALL be ignored.
REQ-015 On IDLE->DRIVE the block SHALL clear fail_mask, err_count and pass, set the vector index to 0, and hold done=0.
REQ-016 DRIVE SHALL last 1 cycle and set {a_out,b_out} to the 2-bit vector index (a_out=MSB); order 00,01,10,11.
REQ-017 WAIT SHALL last exactly SETTLE cycles (down-counter loaded in DRIVE); a_out/b_out SHALL remain stable.
REQ-018 CHECK SHALL last 1 cycle and compare y_in against expected: 00->7'h38, 01->7'h55, 10->7'h55, 11->7'h0B.
REQ-019 On mismatch in CHECK the block SHALL set fail_mask[index] and increment err_count (saturating at 4; saturation is unreachable by construction).
REQ-020 CHECK -> DRIVE with index+1 when index<3; CHECK -> DONE when index=3 (no wrap of index into a second sweep).
REQ-021 DONE SHALL last 1 cycle, assert done=1, set pass=1 iff err_count=0 including the final vector's result, then go to IDLE.
REQ-022 Sweep latency: done SHALL be high in the cycle following exactly 4*(SETTLE+2) edges after the edge that sampled start (SETTLE=2 -> done high after edge 17).
REQ-023 pass, fail_mask and err_count SHALL hold their values from DONE until the next accepted start.
REQ-024 a_out/b_out SHALL hold the last driven vector (11) after a sweep until the next DRIVE.
REQ-025 start held high continuously SHALL launch a new sweep on the edge after DONE returns to IDLE (one idle cycle between sweeps).
REQ-026 X or Z on any y_in bit during CHECK SHALL count as a mismatch.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force state IDLE, index 0, counter 0, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0.
REQ-028 rst asserted mid-sweep SHALL abort the sweep with no done pulse; results SHALL read as reset values.
REQ-029 rst and start high on the same edge: rst SHALL win; start SHALL be acted on only on an edge where rst=0.

Verification
REQ-030 Gate block connected correctly, SETTLE=2, pulse start -> a_out/b_out sequence 00,01,10,11; done pulse after edge 17; pass=1, fail_mask=4'b0000, err_count=0.
REQ-031 y_in bit 1 stuck at 0 (AND fault) -> only vector 11 fails (expected 7'h0B, sees 7'h09); fail_mask=4'b1000, err_count=1, pass=0.
REQ-032 a/b swapped at the gate block -> no failures (symmetric functions); pass=1; y_in forced to 7'h00 -> fail_mask=4'b1111, err_count=4, pass=0.
REQ-033 rst pulsed during WAIT of vector 2 -> all outputs zero asynchronously, no done; subsequent start completes a clean full sweep.
REQ-034 start pulsed while busy=1 -> ignored; exactly one done; start held high -> back-to-back sweeps, done every 4*(SETTLE+2)+1 cycles (17 for SETTLE=2).
REQ-035 SETTLE=1 and SETTLE=15 -> WAIT duration measured as 1 and 15 cycles; done after edges 13 and 69 respectively.
